alu_multicycle_exec: RTL and testbench

//  Execution stage downstream of ALU_Control: consumes the 4-bit ALU operation code and two operands.

---
 rtl/alu_multicycle_exec_pkg.sv | 32 +++
 rtl/alu_multicycle_exec_shifter.sv | 52 +++++
 rtl/alu_multicycle_exec.sv | 169 ++++++++++++++++
 tb/tb_alu_multicycle_exec.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/alu_multicycle_exec_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : alu_multicycle_exec_pkg
// Brief  : Op codes and FSM states shared by the multi-cycle ALU execute stage.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package alu_multicycle_exec_pkg;

  localparam logic [3:0] c_op_add = 4'b0000;
  localparam logic [3:0] c_op_sub = 4'b0001;
  localparam logic [3:0] c_op_or  = 4'b0010;
  localparam logic [3:0] c_op_and = 4'b0011;
  localparam logic [3:0] c_op_lui = 4'b0100;
  localparam logic [3:0] c_op_sll = 4'b0101;
  localparam logic [3:0] c_op_srl = 4'b0110;
  localparam logic [3:0] c_op_xor = 4'b0111;
  localparam logic [3:0] c_op_beq = 4'b1000;
  localparam logic [3:0] c_op_bne = 4'b1001;
  localparam logic [3:0] c_op_blt = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == c_op_sll) || (op == c_op_srl);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_multicycle_exec_shifter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : alu_multicycle_exec_shifter
// Brief  : One-bit-per-cycle logical shifter with shift-amount down-counter.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module alu_multicycle_exec_shifter #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  dir,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [SHAMT_W-1:0]    load_shamt,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] next_data
);

  logic [DATA_WIDTH-1:0] r_data;
  logic [SHAMT_W-1:0]    r_cnt;
  logic                  r_dir;
  logic                  w_dir;
  logic [DATA_WIDTH-1:0] w_src;

  assign w_dir     = load ? dir : r_dir;
  assign w_src     = load ? load_data : r_data;
  assign next_data = w_dir ? (w_src >> 1) : (w_src << 1);
  assign busy      = (r_cnt != '0);
  // done flags the cycle whose shift is the last one; next_data holds the final value
  assign done      = !load && (r_cnt == SHAMT_W'(1));

  // The first shift happens on the load edge, so total latency equals the shift amount.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_dir  <= 1'b0;
    end else if (load) begin
      r_data <= next_data;
      r_cnt  <= load_shamt - SHAMT_W'(1);
      r_dir  <= dir;
    end else if (busy) begin
      r_data <= next_data;
      r_cnt  <= r_cnt - SHAMT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_multicycle_exec.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : alu_multicycle_exec
// Brief  : ALU execute stage; single-cycle logic/arith/compare, serial shifts.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module alu_multicycle_exec
  import alu_multicycle_exec_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [3:0]            alu_op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  branch_o,
  output logic                  illegal_o
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_branch;
  logic                  r_illegal;

  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_branch;
  logic                  w_illegal;
  logic                  w_load_out;

  logic [DATA_WIDTH-1:0] w_alu_res;
  logic                  w_alu_branch;
  logic                  w_alu_illegal;

  logic [SHAMT_W-1:0]    w_shamt;
  logic                  w_shift_load;
  logic                  w_shift_busy;
  logic                  w_shift_done;
  logic [DATA_WIDTH-1:0] w_shift_next;

  assign w_shamt     = b_i[SHAMT_W-1:0];
  assign in_ready_o  = (r_state == S_IDLE);
  assign out_valid_o = (r_state == S_DONE);
  assign result_o    = r_result;
  assign zero_o      = r_zero;
  assign branch_o    = r_branch;
  assign illegal_o   = r_illegal;

  alu_multicycle_exec_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_W    (SHAMT_W)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (w_shift_load),
    .dir        (alu_op_i == c_op_srl),
    .load_data  (a_i),
    .load_shamt (w_shamt),
    .busy       (w_shift_busy),
    .done       (w_shift_done),
    .next_data  (w_shift_next)
  );

  always_comb begin
    w_alu_res     = '0;
    w_alu_branch  = 1'b0;
    w_alu_illegal = 1'b0;
    case (alu_op_i)
      c_op_add: w_alu_res = a_i + b_i;
      c_op_sub: w_alu_res = a_i - b_i;
      c_op_or:  w_alu_res = a_i | b_i;
      c_op_and: w_alu_res = a_i & b_i;
      c_op_lui: w_alu_res = b_i;
      c_op_xor: w_alu_res = a_i ^ b_i;
      c_op_beq: begin
        w_alu_res    = a_i - b_i;
        w_alu_branch = (a_i == b_i);
      end
      c_op_bne: begin
        w_alu_res    = a_i - b_i;
        w_alu_branch = (a_i != b_i);
      end
      c_op_blt: begin
        w_alu_res    = a_i - b_i;
        w_alu_branch = ($signed(a_i) < $signed(b_i));
      end
      c_op_sll, c_op_srl: w_alu_res = '0;
      default:  w_alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_load_out   = 1'b0;
    w_shift_load = 1'b0;
    w_result     = '0;
    w_branch     = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid_i) begin
          w_next_state = S_DONE;
          if (is_shift_op(alu_op_i)) begin
            if (w_shamt == '0) begin
              w_result   = a_i;
              w_load_out = 1'b1;
            end else begin
              w_shift_load = 1'b1;
              if (w_shamt == SHAMT_W'(1)) begin
                w_result   = w_shift_next;
                w_load_out = 1'b1;
              end else begin
                w_next_state = S_SHIFT;
              end
            end
          end else begin
            w_result   = w_alu_res;
            w_branch   = w_alu_branch;
            w_illegal  = w_alu_illegal;
            w_load_out = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (w_shift_done) begin
          w_result     = w_shift_next;
          w_load_out   = 1'b1;
          w_next_state = S_DONE;
        end else if (!w_shift_busy) begin
          w_next_state = S_IDLE;
        end
      end
      S_DONE: begin
        if (out_ready_i) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_branch  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load_out) begin
        r_result  <= w_result;
        r_zero    <= (w_result == '0);
        r_branch  <= w_branch;
        r_illegal <= w_illegal;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle_exec.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_alu_multicycle_exec
// Brief  : Directed-vector bench for the multi-cycle ALU execute stage.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_alu_multicycle_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  alu_op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        branch_o;
  logic        illegal_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alu_multicycle_exec #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .alu_op_i    (alu_op_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .zero_o      (zero_o),
    .branch_o    (branch_o),
    .illegal_o   (illegal_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one op at posedge+1, wait for the result, optionally stall the consumer, then take it.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ez, input logic eb, input logic ei,
                        input int elat, input int hold);
    int lat;
    check({tag, ":in_ready"}, 64'(in_ready_o), 64'(1));
    alu_op_i   = op;
    a_i        = a;
    b_i        = b;
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    alu_op_i   = 4'b0000;
    a_i        = 32'h5A5A_A5A5;
    b_i        = 32'h0000_0003;
    if (elat > 1) check({tag, ":busy"}, 64'(in_ready_o), 64'(0));
    lat = 1;
    while (!out_valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":latency"}, 64'(lat), 64'(elat));
    check({tag, ":result"},  64'(result_o), 64'(er));
    check({tag, ":zero"},    64'(zero_o), 64'(ez));
    check({tag, ":branch"},  64'(branch_o), 64'(eb));
    check({tag, ":illegal"}, 64'(illegal_o), 64'(ei));
    for (int i = 0; i < hold; i++) begin
      in_valid_i = 1'b1;
      alu_op_i   = 4'b0111;
      a_i        = 32'h1234_5678;
      @(posedge clk); #1;
      check({tag, ":hold_result"}, 64'(result_o), 64'(er));
      check({tag, ":hold_valid"},  64'({out_valid_o, in_ready_o}), 64'(2'b10));
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    check({tag, ":released"}, 64'({out_valid_o, in_ready_o}), 64'(2'b01));
  endtask

  initial begin
    reset       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    alu_op_i    = 4'b0000;
    a_i         = '0;
    b_i         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready",   64'(in_ready_o), 64'(1));
    check("reset_valid",   64'(out_valid_o), 64'(0));
    check("reset_outputs", 64'({result_o, zero_o, branch_o, illegal_o}), 64'(0));
    reset = 1'b0;

    run_op("add_wrap", 4'b0000, 32'h7FFF_FFFF, 32'h1,        32'h8000_0000, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("sub_zero", 4'b0001, 32'd5,         32'd5,        32'h0,         1'b1, 1'b0, 1'b0, 1, 0);
    run_op("blt_neg",  4'b1010, 32'hFFFF_FFFF, 32'h1,        32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1, 0);
    run_op("bne_eq",   4'b1001, 32'd7,         32'd7,        32'h0,         1'b1, 1'b0, 1'b0, 1, 0);
    run_op("beq_eq",   4'b1000, 32'd3,         32'd3,        32'h0,         1'b1, 1'b1, 1'b0, 1, 0);
    run_op("sll_31",   4'b0101, 32'h1,         32'd31,       32'h8000_0000, 1'b0, 1'b0, 1'b0, 31, 0);
    run_op("srl_sh0",  4'b0110, 32'hDEAD_BEEF, 32'h20,       32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("srl_4",    4'b0110, 32'h8000_0000, 32'd4,        32'h0800_0000, 1'b0, 1'b0, 1'b0, 4, 0);
    run_op("sll_1",    4'b0101, 32'h3,         32'hFFFF_FFE1, 32'h6,        1'b0, 1'b0, 1'b0, 1, 0);
    run_op("and_bp",   4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1, 10);
    run_op("or_next",  4'b0010, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0, 1'b0, 1, 0);

    // Reset while a 20-bit SRL is in flight
    alu_op_i   = 4'b0110;
    a_i        = 32'hFFFF_FFFF;
    b_i        = 32'd20;
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_shift_busy", 64'({out_valid_o, in_ready_o}), 64'(2'b00));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_handshake", 64'({out_valid_o, in_ready_o}), 64'(2'b01));
    check("abort_outputs",   64'({result_o, zero_o, branch_o, illegal_o}), 64'(0));
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_result", 64'(out_valid_o), 64'(0));

    run_op("add_post_rst", 4'b0000, 32'd2,       32'd3,        32'd5,         1'b0, 1'b0, 1'b0, 1, 0);
    run_op("illegal_f",    4'b1111, 32'd5,       32'd6,        32'h0,         1'b1, 1'b0, 1'b1, 1, 0);
    run_op("illegal_c",    4'b1100, 32'hFFFF,    32'h1,        32'h0,         1'b1, 1'b0, 1'b1, 1, 0);
    run_op("xor",          4'b0111, 32'hF0F0,    32'hFF00,     32'h0FF0,      1'b0, 1'b0, 1'b0, 1, 0);
    run_op("lui",          4'b0100, 32'hFFFF_FFFF, 32'h1234_5000, 32'h1234_5000, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("legal_after",  4'b0000, 32'd0,       32'd0,        32'h0,         1'b1, 1'b0, 1'b0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
